logic_nibble_packer: RTL and testbench
======================================

# logic_nibble_packer

Receive-side packer for the 4-bit qualified data bus used across the data-type examples, where a driver presents a `logic [3:0]` nibble with a one-bit enable. The block samples each enabled nibble, assembles `NIBBLES` nibbles LSB-first into one word, and presents the word on a valid/ready output port. The enable input has no backpressure, so a word that cannot be delivered is dropped and flagged on a sticky overflow bit. The block sits between a nibble-stream driver and any word-wide consumer.

## Interface
- `NIBBLE_W`, 4: width of one input nibble.
- `NIBBLES`, 4: nibbles per output word; legal range 2..8.
- `clk`  in  1  single clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `data_i`  in  NIBBLE_W  input nibble; sampled only when `en_i`=1.
- `en_i`  in  1  nibble qualifier; one nibble is accepted per cycle with `en_i`=1.
- `clear_i`  in  1  synchronous clear of the accumulator, the output slot and `overflow_o`.
- `word_o`  out  NIBBLE_W*NIBBLES  assembled word; nibble 0 is in bits [NIBBLE_W-1:0].
- `word_valid_o`  out  1  output slot holds a word.
- `word_ready_i`  in  1  consumer accepts the word when `word_valid_o`=`word_ready_i`=1.
- `fill_o`  out  $clog2(NIBBLES+1)  nibbles currently held in the accumulator (0..NIBBLES-1).
- `overflow_o`  out  1  sticky flag: at least one completed word was dropped.

## Operation
- Reset: asserting `rst_n`=0 clears all state immediately, regardless of `clk`. The accumulator is 0, `fill_o`=0, `word_o`=0, `word_valid_o`=0 and `overflow_o`=0. Reset takes effect mid-word; a partial word is discarded.
- Accumulator: a NIBBLES-slot register plus a fill counter.
  - When `en_i`=1, `data_i` is written into slot `fill_o` and the counter increments.
  - Slots are filled in index order, so the first nibble received becomes bits [3:0].
- Word completion: when `en_i`=1 and `fill_o`=NIBBLES-1, the word is complete.
  - The counter wraps to 0.
  - The completed word, including the current nibble, is offered to the output slot in the same edge.
- Output slot has two states:
  - EMPTY (`word_valid_o`=0).
  - FULL (`word_valid_o`=1). `word_o` is held stable while FULL.
- Slot transitions on each edge:
  - EMPTY + completion -> FULL, slot loads the word.
  - FULL + handshake, no completion -> EMPTY. `word_o` keeps its last value.
  - FULL + handshake + completion -> FULL, slot loads the new word (no bubble).
  - FULL + no handshake + completion -> FULL, slot unchanged. The new word is dropped and `overflow_o` is set to 1.
- `word_ready_i` has no effect while EMPTY.
- `clear_i`=1 overrides all other inputs in that cycle:
  - next state equals the reset state;
  - the nibble on `data_i` is not captured, even with `en_i`=1.
- `en_i` or `data_i` carrying X/Z is a protocol violation; the bench flags it with an assertion. RTL behaviour in that case is undefined.
- Arithmetic: the fill counter is unsigned, width $clog2(NIBBLES+1), and compares against NIBBLES-1; there is no other arithmetic.

## Timing
- Latency: last nibble presented at edge k -> `word_valid_o`=1 and `word_o` valid immediately after edge k.
- Throughput: one nibble per cycle sustained. One word per NIBBLES cycles, with no loss provided the consumer accepts at least once per NIBBLES cycles.
- Handshake completes on an edge where `word_valid_o`=`word_ready_i`=1. The consumer may hold `word_ready_i` high permanently.
- `fill_o`, `word_valid_o` and `overflow_o` are registered outputs; none depend combinationally on inputs.

## Structure
- Package `nibble_pkg`:
  - default constants `NIBBLE_W_DEF`=4 and `NIBBLES_DEF`=4;
  - enum `slot_state_e` {SLOT_EMPTY, SLOT_FULL};
  - function `fill_width(n)` returning $clog2(n+1).
- One sub-module, `nibble_acc`: the slot register and fill counter with a `done` output.
- The top level holds the output slot FSM and the overflow flag.

## Test plan
- Reset, then check before any edge: all outputs 0. Assert `rst_n` mid-word after 2 nibbles -> `fill_o`=0 asynchronously, and the next 4 nibbles form a clean word.
- Send nibbles 0xB, 0x3, 0xA, 0x5 on consecutive edges with `word_ready_i`=0 -> `word_o`=0x5A3B and `word_valid_o`=1 after the 4th edge, held stable; raise ready -> valid falls after one edge.
- Stream 8 nibbles 0x1..0x8 with `word_ready_i`=1 -> words 0x4321 then 0x8765; valid stays high across the back-to-back handshake-plus-completion edge.
- Hold `word_ready_i`=0 and send 8 nibbles 0x0..0x7 -> `word_o`=0x3210 retained, `overflow_o`=1 and stays 1 after a later handshake; `clear_i` pulse -> `overflow_o`=0, `word_valid_o`=0.
- Gap test: send 0xC, idle 3 cycles with `en_i`=0, then 0xD, 0xE, 0xF -> `word_o`=0xFEDC, with `fill_o` stepping 1 and holding during the gap.
- Assert `clear_i` together with `en_i`=1 on the 4th nibble -> no word produced, `fill_o`=0.

Source files
------------

// File: rtl/logic_nibble_packer_pkg.sv
// Shared constants, slot state encoding and the fill-counter width helper
// for the nibble packer.
package nibble_pkg;

  localparam int NIBBLE_W_DEF = 4;
  localparam int NIBBLES_DEF  = 4;

  typedef enum logic {
    SLOT_EMPTY = 1'b0,
    SLOT_FULL  = 1'b1
  } slot_state_e;

  function automatic int fill_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/logic_nibble_packer_if.sv
// Nibble input bus and word output handshake of the packer. The packer
// side is the slave; the nibble driver / word consumer side is the master.
interface logic_nibble_packer_if
  import nibble_pkg::*;
#(
  parameter int NIBBLE_W = NIBBLE_W_DEF,
  parameter int NIBBLES  = NIBBLES_DEF
);

  logic [NIBBLE_W-1:0]              data_i;
  logic                             en_i;
  logic                             clear_i;
  logic [NIBBLE_W*NIBBLES-1:0]      word_o;
  logic                             word_valid_o;
  logic                             word_ready_i;
  logic [fill_width(NIBBLES)-1:0]   fill_o;
  logic                             overflow_o;

  modport master (
    output data_i, en_i, clear_i, word_ready_i,
    input  word_o, word_valid_o, fill_o, overflow_o
  );

  modport slave (
    input  data_i, en_i, clear_i, word_ready_i,
    output word_o, word_valid_o, fill_o, overflow_o
  );

endinterface

// File: rtl/logic_nibble_packer_acc.sv
// Nibble accumulator: slot registers filled in index order plus a wrapping
// fill counter; done flags the edge on which the last nibble arrives.
module nibble_acc
  import nibble_pkg::*;
#(
  parameter int NIBBLE_W = NIBBLE_W_DEF,
  parameter int NIBBLES  = NIBBLES_DEF
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            clear,
  input  logic                            en,
  input  logic [NIBBLE_W-1:0]             data,
  output logic [fill_width(NIBBLES)-1:0]  fill,
  output logic [NIBBLE_W*NIBBLES-1:0]     word,
  output logic                            done
);

  localparam int FW = fill_width(NIBBLES);

  logic [NIBBLE_W-1:0] slot_q [NIBBLES];
  logic [FW-1:0]       fill_q;

  always_comb begin
    done = en && (fill_q == FW'(NIBBLES - 1));
  end

  // The completed word must include the nibble arriving this cycle, so the
  // slot currently being written is bypassed with the live input.
  always_comb begin
    word = '0;
    for (int i = 0; i < NIBBLES; i++) begin
      word[i*NIBBLE_W +: NIBBLE_W] = (FW'(i) == fill_q) ? data : slot_q[i];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_q <= '0;
      for (int i = 0; i < NIBBLES; i++) slot_q[i] <= '0;
    end else if (clear) begin
      fill_q <= '0;
      for (int i = 0; i < NIBBLES; i++) slot_q[i] <= '0;
    end else if (en) begin
      for (int i = 0; i < NIBBLES; i++) begin
        if (FW'(i) == fill_q) slot_q[i] <= data;
      end
      fill_q <= done ? '0 : fill_q + FW'(1);
    end
  end

  assign fill = fill_q;

endmodule

// File: rtl/logic_nibble_packer.sv
// Receive-side nibble packer: accumulates nibbles LSB-first into words and
// offers them on a single-entry valid/ready slot, flagging dropped words.
module logic_nibble_packer
  import nibble_pkg::*;
#(
  parameter int NIBBLE_W = NIBBLE_W_DEF,
  parameter int NIBBLES  = NIBBLES_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  logic_nibble_packer_if.slave  bus
);

  localparam int FW = fill_width(NIBBLES);
  localparam int WW = NIBBLE_W * NIBBLES;

  slot_state_e    state_q, state_d;
  logic [WW-1:0]  word_q;
  logic [WW-1:0]  word_new;
  logic           overflow_q;
  logic [FW-1:0]  fill;
  logic           done;
  logic           handshake;
  logic           load;
  logic           drop;

  nibble_acc #(
    .NIBBLE_W (NIBBLE_W),
    .NIBBLES  (NIBBLES)
  ) u_acc (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (bus.clear_i),
    .en    (bus.en_i),
    .data  (bus.data_i),
    .fill  (fill),
    .word  (word_new),
    .done  (done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= SLOT_EMPTY;
      word_q     <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      overflow_q <= bus.clear_i ? 1'b0 : (overflow_q | drop);
      if (bus.clear_i)  word_q <= '0;
      else if (load)    word_q <= word_new;
    end
  end

  // A full slot that is handed off on the same edge a new word completes
  // reloads immediately; without the handoff the new word is lost.
  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    drop      = 1'b0;
    handshake = (state_q == SLOT_FULL) && bus.word_ready_i;
    case (state_q)
      SLOT_EMPTY: begin
        if (done) begin
          state_d = SLOT_FULL;
          load    = 1'b1;
        end
      end
      SLOT_FULL: begin
        if (done && handshake) begin
          load = 1'b1;
        end else if (done) begin
          drop = 1'b1;
        end else if (handshake) begin
          state_d = SLOT_EMPTY;
        end
      end
      default: state_d = SLOT_EMPTY;
    endcase
    if (bus.clear_i) begin
      state_d = SLOT_EMPTY;
      load    = 1'b0;
      drop    = 1'b0;
    end
  end

  always_comb begin
    bus.word_valid_o = (state_q == SLOT_FULL);
    bus.word_o       = word_q;
    bus.fill_o       = fill;
    bus.overflow_o   = overflow_q;
  end

endmodule

// File: tb/tb_logic_nibble_packer.sv
// Directed bench for logic_nibble_packer with hand-computed expected values.
module tb_logic_nibble_packer;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic_nibble_packer_if #(.NIBBLE_W(4), .NIBBLES(4)) bus ();

  logic_nibble_packer #(.NIBBLE_W(4), .NIBBLES(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) begin
      assert (!$isunknown({bus.en_i, bus.data_i})) else begin
        errors++;
        $error("[TB] FAIL protocol en/data unknown observed=%b%h", bus.en_i, bus.data_i);
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic checkAll(input string tag, input logic [15:0] expWord,
                          input logic expValid, input logic [2:0] expFill,
                          input logic expOvf);
    checkOutput({tag, ".word"},     32'(bus.word_o),       32'(expWord));
    checkOutput({tag, ".valid"},    32'(bus.word_valid_o), 32'(expValid));
    checkOutput({tag, ".fill"},     32'(bus.fill_o),       32'(expFill));
    checkOutput({tag, ".overflow"}, 32'(bus.overflow_o),   32'(expOvf));
  endtask

  task automatic applyStimulus(input logic en, input logic [3:0] data,
                               input logic ready, input logic clear);
    bus.en_i         = en;
    bus.data_i       = data;
    bus.word_ready_i = ready;
    bus.clear_i      = clear;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    rst_n            = 1'b0;
    bus.en_i         = 1'b0;
    bus.data_i       = 4'h0;
    bus.word_ready_i = 1'b0;
    bus.clear_i      = 1'b0;

    #2;
    checkAll("reset", 16'h0000, 1'b0, 3'd0, 1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Partial word then asynchronous reset mid-cycle
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
    checkOutput("midword.fill", 32'(bus.fill_o), 32'd2);
    rst_n = 1'b0;
    #1;
    checkAll("asyncReset", 16'h0000, 1'b0, 3'd0, 1'b0);
    #1;
    rst_n = 1'b1;

    // Clean word after reset, held without ready, then released
    applyStimulus(1'b1, 4'hB, 1'b0, 1'b0);
    checkOutput("firstNibble.fill", 32'(bus.fill_o), 32'd1);
    applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hA, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h5, 1'b0, 1'b0);
    checkAll("word5A3B", 16'h5A3B, 1'b1, 3'd0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkAll("word5A3B.hold", 16'h5A3B, 1'b1, 3'd0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    checkAll("word5A3B.taken", 16'h5A3B, 1'b0, 3'd0, 1'b0);

    // Back-to-back: handshake and completion on the same edge
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 4'(i), 1'b1, 1'b0);
    checkAll("word4321", 16'h4321, 1'b1, 3'd0, 1'b0);
    for (int i = 5; i <= 7; i++) applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
    checkAll("word4321.hold", 16'h4321, 1'b1, 3'd3, 1'b0);
    applyStimulus(1'b1, 4'h8, 1'b1, 1'b0);
    checkAll("word8765", 16'h8765, 1'b1, 3'd0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    checkAll("word8765.taken", 16'h8765, 1'b0, 3'd0, 1'b0);

    // Overflow: second word dropped while the slot is held
    for (int i = 0; i <= 3; i++) applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
    checkAll("word3210", 16'h3210, 1'b1, 3'd0, 1'b0);
    for (int i = 4; i <= 7; i++) applyStimulus(1'b1, 4'(i), 1'b0, 1'b0);
    checkAll("overflow", 16'h3210, 1'b1, 3'd0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    checkAll("overflow.sticky", 16'h3210, 1'b0, 3'd0, 1'b1);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b1);
    checkAll("clear", 16'h0000, 1'b0, 3'd0, 1'b0);

    // Gap in the nibble stream
    applyStimulus(1'b1, 4'hC, 1'b0, 1'b0);
    checkOutput("gap.fill0", 32'(bus.fill_o), 32'd1);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 4'h9, 1'b0, 1'b0);
      checkAll("gap.idle", 16'h0000, 1'b0, 3'd1, 1'b0);
    end
    applyStimulus(1'b1, 4'hD, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'hE, 1'b0, 1'b0);
    checkOutput("gap.fill3", 32'(bus.fill_o), 32'd3);
    applyStimulus(1'b1, 4'hF, 1'b0, 1'b0);
    checkAll("wordFEDC", 16'hFEDC, 1'b1, 3'd0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b1, 1'b0);
    checkAll("wordFEDC.taken", 16'hFEDC, 1'b0, 3'd0, 1'b0);

    // Clear on the completing nibble wins over capture
    applyStimulus(1'b1, 4'h1, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h2, 1'b0, 1'b0);
    applyStimulus(1'b1, 4'h3, 1'b0, 1'b0);
    checkOutput("preClear.fill", 32'(bus.fill_o), 32'd3);
    applyStimulus(1'b1, 4'h4, 1'b0, 1'b1);
    checkAll("clearWithEn", 16'h0000, 1'b0, 3'd0, 1'b0);
    applyStimulus(1'b0, 4'h0, 1'b0, 1'b0);
    checkAll("clearWithEn.after", 16'h0000, 1'b0, 3'd0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
